// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared encodings and default widths for the EX-stage multiply/divide sequencer.
package ex_muldiv_sequencer_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_OP_DEF   = 3;
  localparam int NB_CNT_DEF  = 6;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign correction applied combinationally to the accumulated result.
module muldiv_datapath #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic               i_is_signed,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  logic [NB_DATA-1:0] hi_q, lo_q, opb_q;
  logic               div_q, neg_res_q, neg_rem_q;

  logic [NB_DATA-1:0]   a_mag, b_mag;
  logic [NB_DATA:0]     mul_sum, div_shift, div_diff;
  logic [NB_DATA-1:0]   hi_d, lo_d;
  logic [2*NB_DATA-1:0] prod, prod_fix;

  always_comb begin
    a_mag = (i_is_signed && i_data_a[NB_DATA-1]) ? -i_data_a : i_data_a;
    b_mag = (i_is_signed && i_data_b[NB_DATA-1]) ? -i_data_b : i_data_b;
  end

  // One iteration: multiply adds the multiplicand when the current multiplier
  // bit is set, then shifts the 2N-bit product right; divide shifts the
  // partial remainder left and keeps the difference only when it is >= 0.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[NB_DATA-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (div_q) begin
      if (!div_diff[NB_DATA]) begin
        hi_d = div_diff[NB_DATA-1:0];
        lo_d = {lo_q[NB_DATA-2:0], 1'b1};
      end else begin
        hi_d = div_shift[NB_DATA-1:0];
        lo_d = {lo_q[NB_DATA-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[NB_DATA:1];
      lo_d = {mul_sum[0], lo_q[NB_DATA-1:1]};
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_load) begin
      hi_q      <= '0;
      lo_q      <= i_is_div ? a_mag : b_mag;
      opb_q     <= i_is_div ? b_mag : a_mag;
      div_q     <= i_is_div;
      neg_res_q <= i_is_signed && (i_data_a[NB_DATA-1] ^ i_data_b[NB_DATA-1]);
      neg_rem_q <= i_is_signed && i_is_div && i_data_a[NB_DATA-1];
    end else if (i_step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Remainder follows the dividend's sign; quotient/product follow sign xor.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    if (div_q) begin
      o_hi = neg_rem_q ? -hi_q : hi_q;
      o_lo = neg_res_q ? -lo_q : lo_q;
    end else begin
      o_hi = prod_fix[2*NB_DATA-1:NB_DATA];
      o_lo = prod_fix[NB_DATA-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: FSM, iteration counter and the
// architectural HI/LO registers around the iterative datapath.
module ex_muldiv_sequencer
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int NB_CNT  = NB_CNT_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic               i_abort,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam logic [NB_DATA-1:0] MIN_NEG = {1'b1, {(NB_DATA-1){1'b0}}};

  state_e             state_q, state_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d;

  logic               dp_load, dp_step, is_div, is_signed;
  logic [NB_DATA-1:0] dp_hi, dp_lo;

  always_comb begin
    is_div    = (i_op == NB_OP'(OP_DIV)) || (i_op == NB_OP'(OP_DIVU));
    is_signed = (i_op == NB_OP'(OP_MULT)) || (i_op == NB_OP'(OP_DIV));
  end

  muldiv_datapath #(.NB_DATA(NB_DATA)) u_datapath (
    .i_clock     (i_clock),
    .i_load      (dp_load),
    .i_step      (dp_step),
    .i_is_div    (is_div),
    .i_is_signed (is_signed),
    .i_data_a    (i_data_a),
    .i_data_b    (i_data_b),
    .o_hi        (dp_hi),
    .o_lo        (dp_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          if (i_op == NB_OP'(OP_MTHI)) begin
            hi_d = i_data_a;
          end else if (i_op == NB_OP'(OP_MTLO)) begin
            lo_d = i_data_a;
          end else if (is_div && (i_data_b == '0)) begin
            hi_d    = i_data_a;
            lo_d    = '1;
            done_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_DONE;
          end else if ((i_op == NB_OP'(OP_DIV)) && (i_data_a == MIN_NEG) && (i_data_b == '1)) begin
            hi_d    = '0;
            lo_d    = MIN_NEG;
            done_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_DONE;
          end else if (is_div || (i_op == NB_OP'(OP_MULT)) || (i_op == NB_OP'(OP_MULTU))) begin
            dp_load = 1'b1;
            cnt_d   = NB_CNT'(NB_DATA);
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          dp_step = 1'b1;
          cnt_d   = cnt_q - NB_CNT'(1);
          if (cnt_q == NB_CNT'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (i_abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hi_d    = dp_hi;
          lo_d    = dp_lo;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench: stimulus pushes expected HI/LO and done cycle; a monitor
// pops and compares on every o_done pulse.
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv_sequencer dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_op     (op),
    .i_abort  (abort),
    .i_data_a (a),
    .i_data_b (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drives a start for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] o, input logic [31:0] da, input logic [31:0] db,
                       input bit push, input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.hi = eh; e.lo = el; e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
    start = 1'b1; op = o; a = da; b = db;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    issue(o, da, db, 1'b1, eh, el, lat);
    wait_idle();
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);

    // MULTU max*max with busy window 1..34 and low at 35
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 34);
    bad = 0;
    for (int k = 1; k <= 34; k++) begin
      if (!busy) bad++;
      if (k < 34) @(negedge clk);
    end
    chk("busy_window", 64'(bad), 64'd0);
    @(negedge clk);
    chk("busy_after", {63'd0, busy}, 64'd0);

    run_op(3'd0, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 34);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run_op(3'd2, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1);

    // MTLO / MTHI in IDLE
    issue(3'd5, 32'hCAFEBABE, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'hCAFEBABE});
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    issue(3'd4, 32'h11112222, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h11112222});

    // Abort sampled at the end of cycle 10
    issue(3'd1, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0, 0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, hi}, {32'd0, 32'h11112222});
    chk("abort_lo", {32'd0, lo}, {32'd0, 32'hCAFEBABE});
    repeat (40) @(negedge clk);
    chk("abort_hold_lo", {32'd0, lo}, {32'd0, 32'hCAFEBABE});

    // Start and MTHI while busy are ignored
    issue(3'd1, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 34);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    op = 3'd4; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("busy_mthi_ignored", {32'd0, hi}, 64'd0);

    // Abort together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 3'd5; a = 32'h00012345;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_lo", {32'd0, lo}, 64'd15);
    chk("abort_start_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of an operation
    issue(3'd4, 32'hA5A5A5A5, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    issue(3'd1, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_hi", {32'd0, hi}, 64'd0);
    chk("rstmid_lo", {32'd0, lo}, 64'd0);
    repeat (40) @(negedge clk);

    chk("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit for the EX stage: MULT, MULTU, DIV, DIVU, plus MTHI/MTLO writes into the architectural HI/LO registers.
- Runs one iterative operation at a time from an internal shift/add-subtract datapath.
- Raises a stall request so the hazard unit freezes IF/ID/EX while it runs.
- Sits beside the ALU; operands come from the same forwarded data_a/data_b paths.

Parameters:
- NB_DATA, 32, operand/HI/LO width.
- NB_OP, 3, operation-select width.
- NB_CNT, 6, iteration counter width; must satisfy 2^NB_CNT > NB_DATA.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  launch request; sampled only in IDLE.
- i_op  in  NB_OP  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (no-op).
- i_abort  in  1  pipeline flush; kills an operation in progress.
- i_data_a  in  NB_DATA  rs operand (multiplicand/dividend, MTHI/MTLO source).
- i_data_b  in  NB_DATA  rt operand (multiplier/divisor).
- o_busy  out  1  stall request, registered.
- o_done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.

Behaviour:
- Reset: state IDLE; o_busy=0, o_done=0, o_hi=0, o_lo=0, counter=0. Reset has priority over every other input, including mid-operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE with i_start=1:
  - op 4: o_hi<=i_data_a next edge; no busy, no done.
  - op 5: o_lo<=i_data_a next edge; no busy, no done.
  - op 6/7: ignored.
  - op 0-3: latch operand magnitudes (absolute values for signed ops) and result-sign flags; counter<=NB_DATA; state<=RUN; o_busy<=1.
- Divide by zero (op 2/3, i_data_b=0): go straight to DONE; result LO=all-ones, HI=i_data_a.
- Signed overflow (op 2, a=0x80000000, b=0xFFFFFFFF): go straight to DONE; LO=0x80000000, HI=0.
- RUN: one iteration per cycle (shift-add for multiply, restoring subtract for divide); counter decrements; when counter reaches 1, state<=FIX.
- FIX: one cycle; apply two's-complement negation per the sign flags.
  - MULT: negate the 2*NB_DATA product if signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - state<=DONE.
- DONE: o_hi/o_lo updated (mul: HI=upper, LO=lower; div: HI=remainder, LO=quotient); o_done=1 for this cycle only; o_busy<=0; state<=IDLE.
- Latency: start sampled at edge 0 → o_done high in cycle NB_DATA+2 (34 for default); o_busy high for cycles 1..NB_DATA+2.
- i_start while not IDLE: ignored.
- MTHI/MTLO while busy: ignored.
- i_abort in RUN/FIX: state<=IDLE, o_busy<=0, HI/LO unchanged, no o_done.
- i_abort in DONE: ignored; the result commits.
- i_abort together with i_start in IDLE: the start is dropped.
- HI/LO change only at DONE, on MTHI/MTLO, or on reset.

Decomposition:
- Shared package: op encodings (OP_MULT..OP_MTLO), state encodings, NB_DATA/NB_CNT defaults.
- One sub-module: muldiv_datapath (shift registers, adder/subtractor, negation logic).
- Sequencer FSM, counter and HI/LO registers stay in the top module.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → o_done in cycle 34; HI=0xFFFFFFFE, LO=0x00000001; o_busy high cycles 1-34.
- MULT a=-7 (0xFFFFFFF9), b=6 → HI=0xFFFFFFFF, LO=0xFFFFFFD6.
- DIV a=-7, b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=0x12345678, b=0 → LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MULTU started, then i_abort at cycle 10 → o_busy low at cycle 11, no o_done, HI/LO hold their prior values. Repeat with i_reset instead → HI=LO=0.
- MTLO 0xCAFEBABE in IDLE → LO updated next cycle, o_busy stays 0. i_start with op 0 issued while busy → ignored; only one o_done pulse.
